// File: rtl/lsh_pkg.sv
// lsh_pkg: shared types for the LSH mapper front end.
//   nuc_t           2-bit nucleotide code
//   NUC_A..NUC_T    nucleotide encoding constants
//   feeder_state_t  sequencing states of window_feeder
package lsh_pkg;

  typedef logic [1:0] nuc_t;

  localparam nuc_t NUC_A = 2'b00;
  localparam nuc_t NUC_C = 2'b01;
  localparam nuc_t NUC_G = 2'b10;
  localparam nuc_t NUC_T = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FILL,
    ST_HASH,
    ST_COMMIT,
    ST_HRST,
    ST_FINAL,
    ST_DRAIN
  } feeder_state_t;

endpackage

// File: rtl/window_shift_buffer.sv
// window_shift_buffer: DEPTH-entry nucleotide shift register.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clear      load all entries with NUC_A (takes priority over shift)
//   i_shift      shift toward index 0, i_nuc enters at DEPTH-1
//   i_nuc        incoming nucleotide
//   o_window     buffer contents, index 0 oldest
module window_shift_buffer
  import lsh_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_shift,
  input  nuc_t i_nuc,
  output nuc_t o_window [0:DEPTH-1]
);

  nuc_t r_buf [0:DEPTH-1];

  // NOTE: this array is a register bank driven straight onto an output port,
  // not a RAM, so every entry is reset; a RAM-style array would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) r_buf[j] <= NUC_A;
    end else if (i_clear) begin
      for (int j = 0; j < DEPTH; j++) r_buf[j] <= NUC_A;
    end else if (i_shift) begin
      for (int j = 0; j < DEPTH - 1; j++) r_buf[j] <= r_buf[j+1];
      r_buf[DEPTH-1] <= i_nuc;
    end
  end

  assign o_window = r_buf;

endmodule

// File: rtl/window_feeder.sv
// window_feeder: assembles overlapping nucleotide windows from a 2-bit stream
// and sequences each one through the downstream window hasher.
//   clk, reset_window_feeder      clock, asynchronous active-low reset
//   nuc_valid/nuc_ready/nuc_data  nucleotide stream handshake and payload
//   nuc_last                      final nucleotide of the sequence
//   is_reference                  sequence kind, latched when a sequence starts
//   window, window_id             current window (index 0 oldest) and its index
//   ready_for_hashing             window stable, hasher may run
//   hashing_is_done               hasher finished with the current window
//   reset_window_hasher           hasher reset pulse (sequence start, between windows)
//   reset_stats                   stats reset pulse (sequence start)
//   is_insert / is_query          per-window commit pulse for reference / read
//   calculate_matched_window      end-of-read pulse
//   seq_done                      sequence fully processed
//   overflow                      sticky: reference ran past its window budget
module window_feeder
  import lsh_pkg::*;
#(
  parameter int WINDOW_SIZE              = 128,
  parameter int KMER_SIZE                = 16,
  parameter int MAX_WINDOWS_IN_REFERENCE = 512
) (
  input  logic        clk,
  input  logic        reset_window_feeder,
  input  logic        nuc_valid,
  output logic        nuc_ready,
  input  nuc_t        nuc_data,
  input  logic        nuc_last,
  input  logic        is_reference,
  output nuc_t        window [0:WINDOW_SIZE-1],
  output logic [31:0] window_id,
  output logic        ready_for_hashing,
  input  logic        hashing_is_done,
  output logic        reset_window_hasher,
  output logic        reset_stats,
  output logic        is_insert,
  output logic        is_query,
  output logic        calculate_matched_window,
  output logic        seq_done,
  output logic        overflow
);

  localparam int STRIDE = WINDOW_SIZE - KMER_SIZE + 1;
  localparam int CNT_W  = $clog2(WINDOW_SIZE + 1);

  feeder_state_t    r_state;
  feeder_state_t    w_next;
  logic             r_is_ref;
  logic             r_last_seen;
  logic             r_overflow;
  logic             r_reset_hold;
  logic [CNT_W-1:0] r_fill_cnt;
  logic [31:0]      r_window_id;

  logic             w_accept;
  logic             w_fill_done;
  logic             w_at_max;
  logic [CNT_W-1:0] w_target;

  assign w_accept    = nuc_valid && nuc_ready;
  // First window needs a full WINDOW_SIZE; later ones only the fresh stride.
  assign w_target    = (r_window_id == '0) ? CNT_W'(WINDOW_SIZE) : CNT_W'(STRIDE);
  assign w_fill_done = (r_fill_cnt + CNT_W'(1)) == w_target;
  assign w_at_max    = r_is_ref && (r_window_id == 32'(MAX_WINDOWS_IN_REFERENCE - 1));

  // NOTE: combinational block assigns its output a default before the case so
  // no path leaves w_next unassigned, which would infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (nuc_valid) w_next = ST_START;
      ST_START:  w_next = ST_FILL;
      ST_FILL:   if (w_accept && (nuc_last || w_fill_done)) w_next = ST_HASH;
      ST_HASH:   if (hashing_is_done) w_next = ST_COMMIT;
      ST_COMMIT: begin
        if (r_last_seen)   w_next = ST_FINAL;
        else if (w_at_max) w_next = ST_DRAIN;
        else               w_next = ST_HRST;
      end
      ST_HRST:   w_next = ST_FILL;
      ST_DRAIN:  if (w_accept && nuc_last) w_next = ST_FINAL;
      ST_FINAL:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_window_feeder) begin
    if (!reset_window_feeder) begin
      r_state      <= ST_IDLE;
      r_is_ref     <= 1'b0;
      r_last_seen  <= 1'b0;
      r_overflow   <= 1'b0;
      r_reset_hold <= 1'b1;
      r_fill_cnt   <= '0;
      r_window_id  <= '0;
    end else begin
      // Downstream resets stay asserted from reset until the first clock.
      r_reset_hold <= 1'b0;
      r_state      <= w_next;
      unique case (r_state)
        ST_IDLE: if (nuc_valid) r_is_ref <= is_reference;
        ST_START: begin
          r_fill_cnt  <= '0;
          r_window_id <= '0;
          r_last_seen <= 1'b0;
        end
        ST_FILL: begin
          if (w_accept) begin
            r_fill_cnt <= r_fill_cnt + CNT_W'(1);
            if (nuc_last) r_last_seen <= 1'b1;
          end
        end
        ST_COMMIT: begin
          if (!r_last_seen) begin
            if (w_at_max) r_overflow  <= 1'b1;
            else          r_window_id <= r_window_id + 32'd1;
          end
        end
        ST_HRST: r_fill_cnt <= '0;
        default: ;
      endcase
    end
  end

  window_shift_buffer #(
    .DEPTH(WINDOW_SIZE)
  ) u_buf (
    .clk      (clk),
    .rst_n    (reset_window_feeder),
    .i_clear  (r_state == ST_START),
    .i_shift  ((r_state == ST_FILL) && w_accept),
    .i_nuc    (nuc_data),
    .o_window (window)
  );

  // Drain consumes the rest of an over-long reference without building windows.
  assign nuc_ready                = (r_state == ST_FILL) || (r_state == ST_DRAIN);
  assign ready_for_hashing        = (r_state == ST_HASH);
  assign reset_stats              = r_reset_hold || (r_state == ST_START);
  assign reset_window_hasher      = r_reset_hold || (r_state == ST_START) || (r_state == ST_HRST);
  assign is_insert                = (r_state == ST_COMMIT) && r_is_ref;
  assign is_query                 = (r_state == ST_COMMIT) && !r_is_ref;
  assign calculate_matched_window = (r_state == ST_FINAL) && !r_is_ref;
  assign seq_done                 = (r_state == ST_FINAL);
  assign overflow                 = r_overflow;
  assign window_id                = r_window_id;

endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder: self-checking bench for window_feeder (W=8, K=4, MAX=2).
// Expected windows come from a sliding-window model over the sent sequence.
module tb_window_feeder;
  import lsh_pkg::*;

  localparam int W   = 8;
  localparam int K   = 4;
  localparam int S   = W - K + 1;
  localparam int MAX = 2;
  localparam int PW  = 2 * W;

  logic        clk = 1'b0;
  logic        reset_window_feeder;
  logic        nuc_valid;
  logic        nuc_ready;
  nuc_t        nuc_data;
  logic        nuc_last;
  logic        is_reference;
  nuc_t        window [0:W-1];
  logic [31:0] window_id;
  logic        ready_for_hashing;
  logic        hashing_is_done;
  logic        reset_window_hasher;
  logic        reset_stats;
  logic        is_insert;
  logic        is_query;
  logic        calculate_matched_window;
  logic        seq_done;
  logic        overflow;

  always #5 clk = ~clk;

  window_feeder #(
    .WINDOW_SIZE(W),
    .KMER_SIZE(K),
    .MAX_WINDOWS_IN_REFERENCE(MAX)
  ) dut (
    .clk                      (clk),
    .reset_window_feeder      (reset_window_feeder),
    .nuc_valid                (nuc_valid),
    .nuc_ready                (nuc_ready),
    .nuc_data                 (nuc_data),
    .nuc_last                 (nuc_last),
    .is_reference             (is_reference),
    .window                   (window),
    .window_id                (window_id),
    .ready_for_hashing        (ready_for_hashing),
    .hashing_is_done          (hashing_is_done),
    .reset_window_hasher      (reset_window_hasher),
    .reset_stats              (reset_stats),
    .is_insert                (is_insert),
    .is_query                 (is_query),
    .calculate_matched_window (calculate_matched_window),
    .seq_done                 (seq_done),
    .overflow                 (overflow)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int hash_delay = 3;

  // Observed per-sequence activity.
  logic [PW-1:0] got_win[$];
  int            got_id[$];
  bit            got_ins[$];
  int            n_calc, n_seq, n_viol;

  // Model state.
  nuc_t          cur_seq[$];
  logic [PW-1:0] exp_win[$];
  bit            ovf_this;
  bit            model_ovf = 1'b0;

  typedef struct {
    bit is_ref;
    int len;
    int hdelay;
    bit gaps;
    int exp_n;
    bit exp_ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  endtask

  function automatic logic [PW-1:0] pack_dut();
    logic [PW-1:0] p;
    for (int j = 0; j < W; j++) p[2*j +: 2] = window[j];
    return p;
  endfunction

  // Hasher stand-in: raises done hash_delay cycles into ready_for_hashing.
  initial begin
    int hcnt;
    hcnt = 0;
    hashing_is_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!ready_for_hashing) begin
        hashing_is_done = 1'b0;
        hcnt = 0;
      end else begin
        hcnt++;
        hashing_is_done = (hcnt >= hash_delay);
      end
    end
  end

  // Monitor: records every committed window and the end-of-sequence pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (is_insert || is_query) begin
        got_win.push_back(pack_dut());
        got_id.push_back(int'(window_id));
        got_ins.push_back(is_insert);
      end
      if (calculate_matched_window) n_calc++;
      if (seq_done) n_seq++;
      if (nuc_ready && (ready_for_hashing || is_insert || is_query || seq_done ||
                        reset_window_hasher || reset_stats || calculate_matched_window))
        n_viol++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Every window is the last W nucleotides seen (zeros before the sequence);
  // window k ends at W-1+k*S or at the final nucleotide, whichever is first.
  task automatic model(input bit is_ref);
    int L, e, p;
    logic [PW-1:0] w;
    exp_win.delete();
    ovf_this = 1'b0;
    L = cur_seq.size();
    e = ((L < W) ? L : W) - 1;
    forever begin
      if (is_ref && exp_win.size() == MAX) begin
        ovf_this = 1'b1;
        break;
      end
      for (int j = 0; j < W; j++) begin
        p = e - (W - 1) + j;
        w[2*j +: 2] = (p >= 0) ? cur_seq[p] : 2'b00;
      end
      exp_win.push_back(w);
      if (e == L - 1) break;
      e = (e + S > L - 1) ? L - 1 : e + S;
    end
  endtask

  // Called at a negedge; returns at the negedge following the last handshake.
  task automatic send_seq(input bit with_last, input bit gaps);
    int guard;
    for (int i = 0; i < cur_seq.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          nuc_valid = 1'b0;
          @(negedge clk);
        end
      end
      nuc_valid = 1'b1;
      nuc_data  = cur_seq[i];
      nuc_last  = with_last && (i == cur_seq.size() - 1);
      guard = 0;
      while (!nuc_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (!nuc_ready) begin
        $display("FAIL handshake_timeout: nucleotide %0d never accepted", i);
        n_miss++;
        summary_and_finish();
      end
      @(negedge clk);
    end
    nuc_valid = 1'b0;
    nuc_last  = 1'b0;
  endtask

  task automatic clear_obs();
    got_win.delete();
    got_id.delete();
    got_ins.delete();
    n_calc = 0;
    n_seq  = 0;
    n_viol = 0;
  endtask

  // exp_n < 0 takes the window count from the model.
  task automatic run_seq(input bit is_ref, input int len, input int hdelay, input bit gaps,
                         input int exp_n, input bit exp_ovf, input string tag);
    int guard, n;
    cur_seq.delete();
    for (int i = 0; i < len; i++) cur_seq.push_back(nuc_t'($urandom_range(0, 3)));
    hash_delay   = hdelay;
    is_reference = is_ref;
    clear_obs();
    model(is_ref);
    model_ovf = model_ovf | ovf_this;
    if (exp_n < 0) exp_n = exp_win.size();
    send_seq(1'b1, gaps);
    guard = 0;
    while (n_seq == 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (n_seq == 0) begin
      $display("FAIL %s_seq_done_timeout: no seq_done seen", tag);
      n_miss++;
      summary_and_finish();
    end
    @(negedge clk);
    check({tag, "_win_count"}, got_win.size(), exp_n);
    n = (got_win.size() < exp_win.size()) ? got_win.size() : exp_win.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_win%0d_data", tag, k), got_win[k], exp_win[k]);
      check($sformatf("%s_win%0d_id", tag, k), got_id[k], k);
      check($sformatf("%s_win%0d_insert", tag, k), got_ins[k], is_ref);
    end
    check({tag, "_calc_count"}, n_calc, is_ref ? 0 : 1);
    check({tag, "_seq_done_count"}, n_seq, 1);
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_ready_only_in_fill"}, n_viol, 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 13,  3, 1'b0, 2, 1'b0};  // reference, two windows
    tbl[1] = '{1'b0, 10,  3, 1'b0, 2, 1'b0};  // read, partial last window
    tbl[2] = '{1'b0,  5,  3, 1'b0, 1, 1'b0};  // read shorter than a window
    tbl[3] = '{1'b0, 13, 20, 1'b1, 2, 1'b0};  // last on stride boundary, slow hasher
    tbl[4] = '{1'b1,  8,  1, 1'b1, 1, 1'b0};  // exactly one window
    tbl[5] = '{1'b0, 14,  2, 1'b1, 3, 1'b0};  // one nucleotide past a boundary
    tbl[6] = '{1'b1, 30,  2, 1'b0, 2, 1'b1};  // reference overflow

    reset_window_feeder = 1'b0;
    nuc_valid    = 1'b0;
    nuc_data     = NUC_A;
    nuc_last     = 1'b0;
    is_reference = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_reset_window_hasher", reset_window_hasher, 1'b1);
    check("rst_reset_stats", reset_stats, 1'b1);
    check("rst_nuc_ready", nuc_ready, 1'b0);
    check("rst_ready_for_hashing", ready_for_hashing, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_window_id", window_id, 0);
    check("rst_window", pack_dut(), 0);
    check("rst_pulses", {is_insert, is_query, calculate_matched_window, seq_done}, 0);
    reset_window_feeder = 1'b1;
    @(negedge clk);
    check("post_rst_reset_window_hasher", reset_window_hasher, 1'b0);
    check("post_rst_reset_stats", reset_stats, 1'b0);

    for (int t = 0; t < 7; t++) begin
      run_seq(tbl[t].is_ref, tbl[t].len, tbl[t].hdelay, tbl[t].gaps,
              tbl[t].exp_n, tbl[t].exp_ovf, $sformatf("tbl%0d", t));
      if (t == 2 && got_win.size() > 0)
        check("tbl2_front_zeros", got_win[0][5:0], 6'd0);
    end

    for (int r = 0; r < 8; r++) begin
      run_seq(1'($urandom_range(0, 1)), $urandom_range(1, 40), $urandom_range(1, 5),
              1'($urandom_range(0, 1)), -1, model_ovf, $sformatf("rnd%0d", r));
    end

    // Reset while a window is waiting on the hasher.
    cur_seq.delete();
    for (int i = 0; i < W; i++) cur_seq.push_back(nuc_t'($urandom_range(0, 3)));
    hash_delay   = 1000;
    is_reference = 1'b1;
    send_seq(1'b0, 1'b0);
    check("midhash_entered", ready_for_hashing, 1'b1);
    repeat (3) @(negedge clk);
    #2 reset_window_feeder = 1'b0;
    #1;
    check("midhash_ready_for_hashing", ready_for_hashing, 1'b0);
    check("midhash_nuc_ready", nuc_ready, 1'b0);
    check("midhash_overflow", overflow, 1'b0);
    check("midhash_window_id", window_id, 0);
    check("midhash_window", pack_dut(), 0);
    check("midhash_reset_window_hasher", reset_window_hasher, 1'b1);
    check("midhash_reset_stats", reset_stats, 1'b1);
    model_ovf  = 1'b0;
    hash_delay = 3;
    @(negedge clk);
    reset_window_feeder = 1'b1;
    @(negedge clk);
    check("midhash_release_resets", {reset_window_hasher, reset_stats}, 2'b00);
    run_seq(1'b0, 9, 2, 1'b0, 2, 1'b0, "after_reset");

    summary_and_finish();
  end

endmodule
